// File: rtl/recon_pkg.sv
// Shared constants for the reconfiguration header path: byte counts, func codes,
// recon header field offsets, FSM state codes and a byte-enable helper.
package recon_pkg;

  localparam logic [15:0] RECON_MAGIC          = 16'hF0E1;
  localparam int unsigned ETH_IP_RMT_HDR_BYTES = 46;
  localparam int unsigned RECON_HDR_BYTES      = 10;
  localparam int unsigned HDR_TOTAL_BYTES      = 56;
  // Magic sits in prefix bytes 42..43.
  localparam int unsigned MAGIC_LSB            = 336;

  localparam logic [1:0] FUNC_WRITE    = 2'd0;
  localparam logic [1:0] FUNC_READ     = 2'd1;
  localparam logic [1:0] FUNC_READBACK = 2'd2;

  localparam int unsigned RH_FUNC_LSB  = 0;
  localparam int unsigned RH_RESP_BIT  = 2;
  localparam int unsigned RH_ADDR_LSB  = 3;
  localparam int unsigned RH_ADDR_BITS = 34;
  localparam int unsigned RH_ID_LSB    = 37;
  localparam int unsigned RH_LEN_LSB   = 45;

  localparam logic [2:0] StIdle    = 3'd0;
  localparam logic [2:0] StDesc    = 3'd1;
  localparam logic [2:0] StFirst   = 3'd2;
  localparam logic [2:0] StData    = 3'd3;
  localparam logic [2:0] StFlush   = 3'd4;
  localparam logic [2:0] StHdrOnly = 3'd5;

  // Low n bytes enabled, n in 0..64.
  function automatic logic [63:0] keep_mask(input logic [6:0] n);
    return (n >= 7'd64) ? '1 : ((64'd1 << n) - 64'd1);
  endfunction

endpackage

// File: rtl/recon_readback_tx_if.sv
// AXI-stream bundle used for both the DMA read data input and the frame output.
interface recon_readback_tx_if #(
  parameter int unsigned DATA_WIDTH = 512,
  parameter int unsigned KEEP_WIDTH = DATA_WIDTH / 8
);
  logic [DATA_WIDTH-1:0] tdata;
  logic [KEEP_WIDTH-1:0] tkeep;
  logic                  tvalid;
  logic                  tlast;
  logic                  tready;

  modport master (output tdata, tkeep, tvalid, tlast, input tready);
  modport slave  (input tdata, tkeep, tvalid, tlast, output tready);
endinterface

// File: rtl/recon_hdr_pack.sv
// Builds the 56-byte frame header: template prefix with magic overlaid, followed by
// the 10-byte readback recon header.
module recon_hdr_pack
  import recon_pkg::*;
(
  input  logic [ETH_IP_RMT_HDR_BYTES*8-1:0] hdr_template,
  input  logic [RH_ADDR_BITS-1:0]           addr,
  input  logic [7:0]                        id,
  input  logic [31:0]                       len,
  output logic [HDR_TOTAL_BYTES*8-1:0]      hdr
);

  logic [ETH_IP_RMT_HDR_BYTES*8-1:0] prefix;
  logic [RECON_HDR_BYTES*8-1:0]      rh;

  always_comb begin
    prefix                          = hdr_template;
    prefix[MAGIC_LSB +: 16]         = RECON_MAGIC;
    rh                              = '0;
    rh[RH_FUNC_LSB +: 2]            = FUNC_READBACK;
    rh[RH_RESP_BIT]                 = 1'b1;
    rh[RH_ADDR_LSB +: RH_ADDR_BITS] = addr;
    rh[RH_ID_LSB +: 8]              = id;
    rh[RH_LEN_LSB +: 32]            = len;
    hdr                             = {rh, prefix};
  end

endmodule

// File: rtl/recon_readback_tx.sv
// Readback transmitter: one DMA read per request, payload shifted behind a 56-byte header.
// Optional RECON_TX_TLAST_CHECK_EN flags DMA tlast misplacement and drains surplus beats.
module recon_readback_tx
  import recon_pkg::*;
#(
  parameter int unsigned DATA_WIDTH         = 512,
  parameter int unsigned KEEP_WIDTH         = DATA_WIDTH / 8,
  parameter int unsigned ADDR_WIDTH         = 34,
  parameter int unsigned DMA_DESC_LEN_WIDTH = 20,
  parameter int unsigned DMA_DESC_TAG_WIDTH = 8,
  parameter int unsigned MAX_LEN            = 8192
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          req_valid,
  output logic                          req_ready,
  input  logic [ADDR_WIDTH-1:0]         req_addr,
  input  logic [31:0]                   req_len,
  input  logic [7:0]                    req_id,
  input  logic [367:0]                  hdr_template,
  output logic [ADDR_WIDTH-1:0]         m_axis_read_desc_addr,
  output logic [DMA_DESC_LEN_WIDTH-1:0] m_axis_read_desc_len,
  output logic [DMA_DESC_TAG_WIDTH-1:0] m_axis_read_desc_tag,
  output logic                          m_axis_read_desc_valid,
  input  logic                          m_axis_read_desc_ready,
  recon_readback_tx_if.slave            s_axis_rd,
  recon_readback_tx_if.master           m_axis,
  output logic                          busy,
  output logic                          err
);

  logic [2:0]                    state_q, state_d;
  logic [ADDR_WIDTH-1:0]         addr_q;
  logic [31:0]                   len_q;
  logic [7:0]                    id_q;
  logic [367:0]                  tmpl_q;
  logic [DMA_DESC_TAG_WIDTH-1:0] tag_q;
  logic                          desc_valid_q, err_q, tail_q;
  logic [7:0]                    beat_cnt_q;
  logic [HDR_TOTAL_BYTES*8-1:0]  prev_q, hdr;
  logic [DATA_WIDTH-1:0]         out_data_q;
  logic [KEEP_WIDTH-1:0]         out_keep_q;
  logic                          out_valid_q, out_last_q;

  logic        adv, in_stream, data_fire, frame_done, drain_active, last_beat;
  logic [14:0] len_rnd;
  logic [7:0]  n_in;
  logic [6:0]  rem;

  recon_hdr_pack u_hdr_pack (
    .hdr_template(tmpl_q),
    .addr        (addr_q),
    .id          (id_q),
    .len         (len_q),
    .hdr         (hdr)
  );

  assign len_rnd   = 15'(len_q[13:0]) + 15'd63;
  assign n_in      = 8'(len_rnd >> 6);
  assign rem       = (len_q[5:0] == 6'd0) ? 7'd64 : {1'b0, len_q[5:0]};
  assign last_beat = (beat_cnt_q == n_in - 8'd1);

  assign adv       = !out_valid_q || m_axis.tready;
  // Input is closed once the tlast beat is sitting in the output register.
  assign in_stream = ((state_q == StFirst) || (state_q == StData)) && !tail_q;
  assign data_fire = s_axis_rd.tvalid && in_stream && adv;

`ifdef RECON_TX_TLAST_CHECK_EN
  logic drain_q;
  assign s_axis_rd.tready = (in_stream && adv) || drain_q;
  assign drain_active     = drain_q && !(s_axis_rd.tvalid && s_axis_rd.tlast);
`else
  assign s_axis_rd.tready = in_stream && adv;
  assign drain_active     = 1'b0;
`endif

  assign frame_done = tail_q && adv && !drain_active;

  logic unused_in;
  assign unused_in = ^{s_axis_rd.tkeep, s_axis_rd.tlast};

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (req_valid && (req_len <= MAX_LEN)) begin
          state_d = (req_len == 32'd0) ? StHdrOnly : StDesc;
        end
      end
      StDesc:  if (m_axis_read_desc_ready) state_d = StFirst;
      StFirst, StData: begin
        if (data_fire) state_d = (last_beat && (rem > 7'd8)) ? StFlush : StData;
        if (frame_done) state_d = StIdle;
      end
      StFlush, StHdrOnly: if (frame_done) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      addr_q       <= '0;
      len_q        <= '0;
      id_q         <= '0;
      tmpl_q       <= '0;
      tag_q        <= '0;
      desc_valid_q <= 1'b0;
      err_q        <= 1'b0;
      tail_q       <= 1'b0;
      beat_cnt_q   <= '0;
      prev_q       <= '0;
      out_data_q   <= '0;
      out_keep_q   <= '0;
      out_valid_q  <= 1'b0;
      out_last_q   <= 1'b0;
`ifdef RECON_TX_TLAST_CHECK_EN
      drain_q      <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      err_q   <= 1'b0;
      if (m_axis.tready) out_valid_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (req_valid) begin
            addr_q     <= req_addr;
            len_q      <= req_len;
            id_q       <= req_id;
            tmpl_q     <= hdr_template;
            beat_cnt_q <= '0;
            if (req_len > MAX_LEN) err_q <= 1'b1;
            else if (req_len != 32'd0) desc_valid_q <= 1'b1;
          end
        end
        StDesc: begin
          if (m_axis_read_desc_ready) begin
            desc_valid_q <= 1'b0;
            tag_q        <= tag_q + 1'b1;
          end
        end
        StFirst, StData: begin
          if (data_fire) begin
            out_data_q  <= {s_axis_rd.tdata[63:0], (state_q == StFirst) ? hdr : prev_q};
            prev_q      <= s_axis_rd.tdata[DATA_WIDTH-1:64];
            out_valid_q <= 1'b1;
            beat_cnt_q  <= beat_cnt_q + 8'd1;
            out_keep_q  <= '1;
            out_last_q  <= 1'b0;
            if (last_beat && (rem <= 7'd8)) begin
              out_keep_q <= KEEP_WIDTH'(keep_mask(7'd56 + rem));
              out_last_q <= 1'b1;
              tail_q     <= 1'b1;
            end
          end
        end
        StFlush, StHdrOnly: begin
          if (adv && !tail_q) begin
            out_data_q  <= {64'd0, (state_q == StFlush) ? prev_q : hdr};
            out_keep_q  <= KEEP_WIDTH'(keep_mask((state_q == StFlush) ? rem - 7'd8 : 7'd56));
            out_last_q  <= 1'b1;
            out_valid_q <= 1'b1;
            tail_q      <= 1'b1;
          end
        end
        default: ;
      endcase
      if (frame_done) tail_q <= 1'b0;
`ifdef RECON_TX_TLAST_CHECK_EN
      if (data_fire) begin
        if (s_axis_rd.tlast != last_beat) err_q <= 1'b1;
        if (last_beat && !s_axis_rd.tlast) drain_q <= 1'b1;
      end
      if (drain_q && s_axis_rd.tvalid && s_axis_rd.tlast) drain_q <= 1'b0;
`endif
    end
  end

  assign req_ready              = (state_q == StIdle);
  assign busy                   = (state_q != StIdle);
  assign err                    = err_q;
  assign m_axis_read_desc_addr  = addr_q;
  assign m_axis_read_desc_len   = DMA_DESC_LEN_WIDTH'(len_q);
  assign m_axis_read_desc_tag   = tag_q;
  assign m_axis_read_desc_valid = desc_valid_q;
  assign m_axis.tdata           = out_data_q;
  assign m_axis.tkeep           = out_keep_q;
  assign m_axis.tvalid          = out_valid_q;
  assign m_axis.tlast           = out_last_q;

endmodule

// File: tb/tb_recon_readback_tx.sv
// Randomized bench for recon_readback_tx: a byte-level frame model (prefix, header,
// payload chopped into 64-byte beats) scores every output beat.
module tb_recon_readback_tx;

  logic         clk = 1'b0;
  logic         rst;
  logic         req_valid, req_ready;
  logic [33:0]  req_addr;
  logic [31:0]  req_len;
  logic [7:0]   req_id;
  logic [367:0] hdr_template;
  logic [33:0]  desc_addr;
  logic [19:0]  desc_len;
  logic [7:0]   desc_tag;
  logic         desc_valid, desc_ready;
  logic         busy, err;

  recon_readback_tx_if rd_if ();
  recon_readback_tx_if tx_if ();

  recon_readback_tx dut (
    .clk                   (clk),
    .rst                   (rst),
    .req_valid             (req_valid),
    .req_ready             (req_ready),
    .req_addr              (req_addr),
    .req_len               (req_len),
    .req_id                (req_id),
    .hdr_template          (hdr_template),
    .m_axis_read_desc_addr (desc_addr),
    .m_axis_read_desc_len  (desc_len),
    .m_axis_read_desc_tag  (desc_tag),
    .m_axis_read_desc_valid(desc_valid),
    .m_axis_read_desc_ready(desc_ready),
    .s_axis_rd             (rd_if),
    .m_axis                (tx_if),
    .busy                  (busy),
    .err                   (err)
  );

  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_errs   = 0;
  logic [7:0]  tb_tag   = 8'd0;

  task automatic check_eq(input string tag, input logic [511:0] got, input logic [511:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_idle(input string tag);
    check_eq({tag, "_tvalid"}, 512'(tx_if.tvalid), 512'(0));
    check_eq({tag, "_desc_valid"}, 512'(desc_valid), 512'(0));
    check_eq({tag, "_rd_tready"}, 512'(rd_if.tready), 512'(0));
    check_eq({tag, "_busy"}, 512'(busy), 512'(0));
    check_eq({tag, "_req_ready"}, 512'(req_ready), 512'(1));
  endtask

  function automatic logic [63:0] byte_mask(input int n);
    logic [63:0] m = '0;
    for (int i = 0; i < n; i++) m[i] = 1'b1;
    return m;
  endfunction

  task automatic reject(input int len);
    int dv = 0;
    @(negedge clk);
    req_valid = 1'b1; req_len = 32'(len); req_addr = 34'($urandom); req_id = 8'($urandom);
    @(negedge clk);
    req_valid = 1'b0;
    #1;
    check_eq("rej_err_pulse", 512'(err), 512'(1));
    check_eq("rej_req_ready", 512'(req_ready), 512'(1));
    @(negedge clk);
    #1;
    check_eq("rej_err_one_cycle", 512'(err), 512'(0));
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      #1;
      if (desc_valid) dv++;
    end
    check_eq("rej_no_desc", 512'(dv), 512'(0));
    check_idle("rej_idle");
  endtask

  task automatic run_frame(input logic [33:0] addr, input int len, input logic [7:0] id,
                           input int tready_pct, input int abort_cyc);
    logic [7:0]   pay[$];
    logic [7:0]   frame[$];
    logic [367:0] tmpl;
    logic [79:0]  rh;
    logic [511:0] exp_data, bmask, hold_data;
    logic [63:0]  exp_keep, hold_keep;
    logic         hold_last, hold_pend, offering, desc_seen;
    int n_in, n_out, total, last_bytes, in_idx, out_idx, desc_cnt, err_cnt, idx;

    for (int i = 0; i < 46; i++) tmpl[8*i +: 8] = 8'($urandom);
    for (int i = 0; i < len; i++) pay.push_back(8'($urandom));
    rh = 80'd2 + (80'd1 << 2) + (80'(addr) << 3) + (80'(id) << 37) + (80'(32'(len)) << 45);
    for (int i = 0; i < 46; i++) frame.push_back(i == 42 ? 8'hE1 : i == 43 ? 8'hF0 : tmpl[8*i +: 8]);
    for (int i = 0; i < 10; i++) frame.push_back(rh[8*i +: 8]);
    for (int i = 0; i < len; i++) frame.push_back(pay[i]);
    n_in       = (len + 63) / 64;
    total      = 56 + len;
    n_out      = (total + 63) / 64;
    last_bytes = total - 64 * (n_out - 1);

    @(negedge clk);
    req_valid = 1'b1; req_addr = addr; req_len = 32'(len); req_id = id; hdr_template = tmpl;
    #1;
    check_eq("req_ready", 512'(req_ready), 512'(1));
    @(negedge clk);
    req_valid = 1'b0;
    #1;
    check_eq("accept_no_err", 512'(err), 512'(0));

    in_idx = 0; out_idx = 0; desc_cnt = 0; err_cnt = 0;
    hold_pend = 1'b0; offering = 1'b0; desc_seen = 1'b0;
    for (int cyc = 0; cyc < 5000; cyc++) begin
      @(negedge clk);
      if (abort_cyc > 0 && cyc == abort_cyc) begin
        rst = 1'b1;
        rd_if.tvalid = 1'b0; tx_if.tready = 1'b0; desc_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        tb_tag = 8'd0;
        #1;
        check_idle("abort");
        check_eq("abort_err", 512'(err), 512'(0));
        return;
      end
      desc_ready = ($urandom_range(0, 99) < 70);
      if (desc_seen && !offering && in_idx < n_in && $urandom_range(0, 99) < 75) begin
        offering = 1'b1;
        for (int j = 0; j < 64; j++) begin
          idx = 64 * in_idx + j;
          rd_if.tdata[8*j +: 8] = (idx < len) ? pay[idx] : 8'($urandom);
          rd_if.tkeep[j]        = (idx < len);
        end
        rd_if.tlast = (in_idx == n_in - 1);
      end
      rd_if.tvalid = offering;
      tx_if.tready = ($urandom_range(0, 99) < tready_pct);
      #1;
      if (err) err_cnt++;
      if (desc_valid && desc_ready) begin
        check_eq("desc_addr", 512'(desc_addr), 512'(addr));
        check_eq("desc_len", 512'(desc_len), 512'(len));
        check_eq("desc_tag", 512'(desc_tag), 512'(tb_tag));
        tb_tag    = tb_tag + 8'd1;
        desc_seen = 1'b1;
        desc_cnt++;
      end
      if (offering && rd_if.tready) begin
        offering = 1'b0;
        in_idx++;
      end
      if (hold_pend) begin
        check_eq("hold_valid", 512'(tx_if.tvalid), 512'(1));
        check_eq("hold_data", tx_if.tdata, hold_data);
        check_eq("hold_keep_last", 512'({tx_if.tkeep, tx_if.tlast}), 512'({hold_keep, hold_last}));
      end
      hold_pend = 1'b0;
      if (tx_if.tvalid) begin
        if (out_idx >= n_out) begin
          check_eq("extra_beat", 512'(tx_if.tvalid), 512'(0));
        end else if (tx_if.tready) begin
          exp_data = '0; bmask = '0;
          for (int j = 0; j < 64; j++) begin
            idx = 64 * out_idx + j;
            if (idx < total) begin
              exp_data[8*j +: 8] = frame[idx];
              bmask[8*j +: 8]    = 8'hFF;
            end
          end
          exp_keep = (out_idx == n_out - 1) ? byte_mask(last_bytes) : '1;
          check_eq($sformatf("data[%0d]", out_idx), tx_if.tdata & bmask, exp_data);
          check_eq($sformatf("keep[%0d]", out_idx), 512'(tx_if.tkeep), 512'(exp_keep));
          check_eq($sformatf("last[%0d]", out_idx), 512'(tx_if.tlast), 512'(out_idx == n_out - 1));
          out_idx++;
        end else begin
          hold_pend = 1'b1;
          hold_data = tx_if.tdata; hold_keep = tx_if.tkeep; hold_last = tx_if.tlast;
        end
      end
      if (out_idx == n_out) break;
    end

    @(negedge clk);
    rd_if.tvalid = 1'b0; tx_if.tready = 1'b0; desc_ready = 1'b0;
    #1;
    check_eq("beats_out", 512'(out_idx), 512'(n_out));
    check_eq("beats_in", 512'(in_idx), 512'(n_in));
    check_eq("desc_count", 512'(desc_cnt), 512'(len == 0 ? 0 : 1));
    check_eq("frame_no_err", 512'(err_cnt), 512'(0));
    check_idle("post_frame");
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_addr = '0; req_len = '0; req_id = '0;
    hdr_template = '0; desc_ready = 1'b0;
    rd_if.tdata = '0; rd_if.tkeep = '0; rd_if.tvalid = 1'b0; rd_if.tlast = 1'b0;
    tx_if.tready = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    check_idle("reset");
    check_eq("reset_err", 512'(err), 512'(0));
    check_eq("reset_tag", 512'(desc_tag), 512'(0));

    run_frame(34'h1_0000_0000, 8, 8'h5A, 100, 0);
    run_frame(34'($urandom), 200, 8'($urandom), 100, 0);
    run_frame(34'($urandom), 100, 8'($urandom), 100, 0);
    run_frame(34'($urandom), 0, 8'($urandom), 100, 0);
    reject(9000);
    reject(8193);
    run_frame(34'($urandom), 512, 8'($urandom), 50, 12);
    run_frame(34'($urandom), 64, 8'($urandom), 50, 0);
    for (int t = 0; t < 10; t++) begin
      run_frame(34'($urandom), $urandom_range(1, 400), 8'($urandom),
                $urandom_range(30, 100), 0);
    end
    run_frame(34'($urandom), 72, 8'($urandom), 60, 0);
    run_frame(34'($urandom), 8192, 8'($urandom), 80, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_checks, n_errs);
    $finish;
  end

endmodule

// File: doc/recon_readback_tx.md
Name: recon_readback_tx

Overview:
- Transmit-side counterpart of the reconfiguration receive controller.
- On a readback request it issues one DMA read descriptor for the stored bitstream region.
- It takes the returned DMA read data stream and emits one Ethernet frame on the app TX stream.
- Frame layout: 46-byte ETH/IP/RMT prefix, then the 10-byte recon header, then the payload realigned by 56 bytes.

Parameters:
- DATA_WIDTH, 512, stream data width in bits; only 512 is supported.
- KEEP_WIDTH, DATA_WIDTH/8, tkeep width.
- ADDR_WIDTH, 34, DMA address width.
- DMA_DESC_LEN_WIDTH, 20, DMA length width.
- DMA_DESC_TAG_WIDTH, 8, DMA tag width.
- MAX_LEN, 8192, largest payload in bytes accepted per request.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- req_valid  in  1  readback request valid
- req_ready  out  1  request accepted (high only in IDLE)
- req_addr  in  ADDR_WIDTH  bitstream host address
- req_len  in  32  payload bytes
- req_id  in  8  bitstream id
- hdr_template  in  368  46-byte prefix, byte 0 at bits [7:0]
- m_axis_read_desc_addr  out  ADDR_WIDTH  DMA read address
- m_axis_read_desc_len  out  DMA_DESC_LEN_WIDTH  DMA read length
- m_axis_read_desc_tag  out  DMA_DESC_TAG_WIDTH  DMA read tag
- m_axis_read_desc_valid  out  1  descriptor valid
- m_axis_read_desc_ready  in  1  descriptor ready
- s_axis_rd_tdata  in  DATA_WIDTH  DMA read data
- s_axis_rd_tkeep  in  KEEP_WIDTH  DMA read byte enables
- s_axis_rd_tvalid  in  1  DMA read data valid
- s_axis_rd_tlast  in  1  DMA read last beat
- s_axis_rd_tready  out  1  DMA read data ready
- m_axis_tdata  out  DATA_WIDTH  frame data
- m_axis_tkeep  out  KEEP_WIDTH  frame byte enables
- m_axis_tvalid  out  1  frame valid
- m_axis_tlast  out  1  frame last beat
- m_axis_tready  in  1  frame ready
- busy  out  1  high whenever state is not IDLE
- err  out  1  one-cycle pulse on a rejected request

Behaviour:
- Reset: state IDLE. m_axis_tvalid, m_axis_read_desc_valid, s_axis_rd_tready, err and busy are 0. Tag counter and outputs are 0. Reset mid-frame abandons the frame without emitting tlast.
- IDLE:
  - On req_valid, latch addr/len/id/hdr_template.
  - If req_len > MAX_LEN: pulse err and stay in IDLE.
  - If req_len == 0: go to HDR_ONLY.
  - Otherwise drive the descriptor (addr, len, tag = counter) with valid=1 and go to DESC.
- DESC: hold the descriptor stable until ready; on ready, deassert valid, increment tag (wraps mod 2^8), go to FIRST.
- Recon header (80 bits):
  - [1:0] = 2'd2 (readback response)
  - [2] = 1
  - [36:3] = addr
  - [44:37] = id
  - [76:45] = len
  - [79:77] = 0
- Prefix: bytes 42..43 (bits 351:336) are overwritten with 16'hF0E1.
- Output beat 0: prefix in bytes 0..45, recon header in bytes 46..55, input beat 0 bytes 0..7 in bytes 56..63.
- Output beat k ≥ 1: input beat k-1 bytes 8..63 in bytes 0..55, input beat k bytes 0..7 in bytes 56..63.
- Output register is a single stage. Advance condition is adv = !m_axis_tvalid || m_axis_tready.
- s_axis_rd_tready = adv while in FIRST or DATA.
- Output beat k appears one cycle after input beat k is accepted.
- Counting: N_in = ceil(len/64); r = len mod 64, with 0 treated as 64.
- FIRST → DATA on the first accepted beat. When the last input beat is accepted:
  - r ≤ 8: that output beat carries tlast, tkeep = 2^(56+r)-1 (r<8) or all ones (r=8); go to IDLE once it is accepted.
  - r > 8: go to FLUSH. FLUSH emits leftover bytes with tkeep = 2^(r-8)-1 and tlast.
- HDR_ONLY: emit a single beat with tkeep = 2^56-1 and tlast; no DMA traffic.
- Input tkeep is ignored; the byte count comes from len only.
- Output data and tkeep are held while tvalid && !tready.
- busy is high in every state except IDLE.

Optional Feature:
- Macro RECON_TX_TLAST_CHECK_EN.
- Defined:
  - If input tlast arrives before beat N_in, or is absent on beat N_in: err pulses on that beat.
  - The frame is still closed at the computed length.
  - Extra input beats after N_in are drained (tready=1, no output) until tlast.
- Undefined: input tlast is ignored and err is produced only by the length check.

Decomposition:
- Package recon_pkg holds:
  - Constants RECON_MAGIC=16'hF0E1, ETH_IP_RMT_HDR_BYTES=46, RECON_HDR_BYTES=10, HDR_TOTAL_BYTES=56.
  - Func-type codes WRITE=0, READ=1, READBACK=2.
  - The recon header field offsets.
  - The state enum.
- One sub-module, recon_hdr_pack, which is combinational: it builds the 56-byte header from template/addr/id/len. It is shared with the receive side for field offsets.

Test Plan:
- len=8, id=0x5A, addr=0x1_0000_0000, desc ready immediately → one input beat, one output beat with tkeep=all ones and tlast; bits 351:336=F0E1; header[1:0]=2, [76:45]=8.
- len=200 → 4 input beats; r=8 so 4 output beats; last tkeep=all ones with tlast; payload byte 199 lands at output beat 3 byte 63.
- len=100 → 2 input beats plus FLUSH; 3 output beats; last tkeep=2^28-1; tag increments 0→1 on the second request.
- len=0 → single beat with tkeep=2^56-1 and tlast; m_axis_read_desc_valid never rises.
- len=9000 → err pulses, req_ready stays high, no descriptor issued.
- m_axis_tready toggling 50% plus rst asserted mid-frame at len=512 → data holds during stalls; after rst all valids are 0 and state is IDLE.
